// File: rtl/ucode_pkg.sv
// Shared opcode constants, control-state encodings and sequence-entry type
// for the microcode sequencer and its sequence ROM.
package ucode_pkg;

    localparam int OP_W_DEF    = 8;
    localparam int STATE_W_DEF = 8;
    localparam int T_MAX_DEF   = 8;
    localparam int SEQ_MAX     = 6;   // longest post-decode sequence (CALL)

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HLT  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_LDI  = 8'h03;
    localparam logic [7:0] OP_LDX  = 8'h04;
    localparam logic [7:0] OP_STX  = 8'h05;
    localparam logic [7:0] OP_CMP  = 8'h06;
    localparam logic [7:0] OP_ALU  = 8'h07;
    localparam logic [7:0] OP_PUSH = 8'h08;
    localparam logic [7:0] OP_POP  = 8'h09;
    localparam logic [7:0] OP_JMP  = 8'h0A;
    localparam logic [7:0] OP_CALL = 8'h0B;
    localparam logic [7:0] OP_RET  = 8'h0C;
    localparam logic [7:0] OP_LDA  = 8'h0D;
    localparam logic [7:0] OP_STA  = 8'h0E;

    typedef enum logic [7:0] {
        STATE_IDLE        = 8'd0,
        STATE_FETCH_PC    = 8'd1,
        STATE_FETCH_INST  = 8'd2,
        STATE_NEXT        = 8'd3,
        STATE_HALT        = 8'd4,
        STATE_TRAP        = 8'd5,
        STATE_INT_PUSH_PC = 8'd6,
        STATE_INT_VECTOR  = 8'd7,
        STATE_MOV_REG     = 8'd8,
        STATE_SET_REG     = 8'd9,
        STATE_SET_MEM     = 8'd10,
        STATE_LOAD_ADDR   = 8'd11,
        STATE_ALU_EXEC    = 8'd12,
        STATE_ALU_OUT     = 8'd13,
        STATE_FETCH_SP    = 8'd14,
        STATE_STACK_REG   = 8'd15,
        STATE_INC_SP      = 8'd16,
        STATE_JUMP        = 8'd17,
        STATE_STORE_PC    = 8'd18,
        STATE_TMP_JUMP    = 8'd19,
        STATE_RET         = 8'd20,
        STATE_SET_MAR     = 8'd21
    } state_e;

    typedef struct packed {
        state_e state;
        logic   last;
    } seq_entry_t;

    function automatic logic is_last(input state_e s);
        return (s == STATE_NEXT) || (s == STATE_HALT);
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational sequence table: (opcode, current T-cycle) -> entry for the
// following T-cycle. valid_o is low for opcodes with no sequence.
module ucode_rom
    import ucode_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = $clog2(T_MAX_DEF)
) (
    input  logic [OP_W-1:0]  opcode_i,
    input  logic [CNT_W-1:0] t_cycle_i,
    output seq_entry_t       entry_o,
    output logic             valid_o
);

    state_e           seq [SEQ_MAX];
    logic [CNT_W-1:0] idx;

    // Entry 0 is the state at T2, selected while the sequencer sits in T1.
    assign idx = t_cycle_i - CNT_W'(1);

    // NOTE: every variable is given a default before the case so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        seq     = '{default: STATE_NEXT};
        valid_o = 1'b1;
        case (opcode_i)
            OP_W'(OP_NOP):  ;
            OP_W'(OP_HLT):  seq[0] = STATE_HALT;
            OP_W'(OP_MOV):  seq[0] = STATE_MOV_REG;
            OP_W'(OP_LDI):  begin seq[0] = STATE_FETCH_PC; seq[1] = STATE_SET_REG; end
            OP_W'(OP_LDX):  begin seq[0] = STATE_FETCH_PC; seq[1] = STATE_LOAD_ADDR; seq[2] = STATE_SET_REG; end
            OP_W'(OP_STX):  begin seq[0] = STATE_FETCH_PC; seq[1] = STATE_LOAD_ADDR; seq[2] = STATE_SET_MEM; end
            OP_W'(OP_CMP):  seq[0] = STATE_ALU_EXEC;
            OP_W'(OP_ALU):  begin seq[0] = STATE_ALU_EXEC; seq[1] = STATE_ALU_OUT; end
            OP_W'(OP_PUSH): begin seq[0] = STATE_FETCH_SP; seq[1] = STATE_STACK_REG; end
            OP_W'(OP_POP):  begin seq[0] = STATE_INC_SP; seq[1] = STATE_FETCH_SP; seq[2] = STATE_SET_REG; end
            OP_W'(OP_JMP):  begin seq[0] = STATE_FETCH_PC; seq[1] = STATE_JUMP; end
            OP_W'(OP_CALL): begin
                seq[0] = STATE_FETCH_PC;
                seq[1] = STATE_SET_REG;
                seq[2] = STATE_FETCH_SP;
                seq[3] = STATE_STORE_PC;
                seq[4] = STATE_TMP_JUMP;
            end
            OP_W'(OP_RET):  begin seq[0] = STATE_INC_SP; seq[1] = STATE_FETCH_SP; seq[2] = STATE_RET; end
            OP_W'(OP_LDA):  begin seq[0] = STATE_SET_MAR; seq[1] = STATE_SET_REG; end
            OP_W'(OP_STA):  begin seq[0] = STATE_SET_MAR; seq[1] = STATE_SET_MEM; end
            default:        valid_o = 1'b0;
        endcase

        entry_o.state = STATE_NEXT;
        for (int i = 0; i < SEQ_MAX; i++) begin
            if (int'(idx) == i) entry_o.state = seq[i];
        end
        entry_o.last = is_last(entry_o.state);
    end

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: T-cycle counter, opcode latch, bus-ready stalls,
// interrupt entry, illegal/overrun trap and halt with interrupt wake-up.
module ucode_seq
    import ucode_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int STATE_W = STATE_W_DEF,
    parameter int T_MAX   = T_MAX_DEF,
    parameter int CNT_W   = $clog2(T_MAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               ready,
    input  logic               irq,
    input  logic               ie,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   t_cycle,
    output logic               irq_ack,
    output logic               halted,
    output logic               illegal
);

    state_e           state_q;
    logic [CNT_W-1:0] t_q;
    logic [OP_W-1:0]  op_q;
    logic             irq_ack_q;
    logic             halted_q;
    logic             illegal_q;

    logic [OP_W-1:0]  rom_op;
    seq_entry_t       rom_entry;
    logic             rom_valid;
    logic [CNT_W-1:0] t_inc;
    logic             overrun;

    // Decode in T1 looks at the live opcode; later T-cycles use the latch.
    assign rom_op  = (state_q == STATE_FETCH_INST) ? opcode : op_q;
    assign t_inc   = t_q + CNT_W'(1);
    assign overrun = (t_q == CNT_W'(T_MAX - 2)) && !rom_entry.last;

    ucode_rom #(
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) u_rom (
        .opcode_i  (rom_op),
        .t_cycle_i (t_q),
        .entry_o   (rom_entry),
        .valid_o   (rom_valid)
    );

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STATE_IDLE;
            t_q       <= '0;
            op_q      <= '0;
            irq_ack_q <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            halted_q  <= 1'b0;
            case (state_q)
                STATE_IDLE: begin
                    state_q <= STATE_FETCH_PC;
                    t_q     <= '0;
                end
                STATE_NEXT, STATE_HALT: begin
                    if (irq && ie) begin
                        state_q <= STATE_INT_PUSH_PC;
                        t_q     <= t_inc;
                    end else if (state_q == STATE_NEXT) begin
                        state_q <= STATE_FETCH_PC;
                        t_q     <= '0;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                STATE_INT_PUSH_PC: if (ready) begin
                    state_q   <= STATE_INT_VECTOR;
                    t_q       <= t_inc;
                    irq_ack_q <= 1'b1;
                end
                STATE_INT_VECTOR: if (ready) begin
                    state_q <= STATE_FETCH_PC;
                    t_q     <= '0;
                end
                STATE_TRAP: if (ready) begin
                    state_q  <= STATE_HALT;
                    t_q      <= t_inc;
                    halted_q <= 1'b1;
                end
                default: if (ready) begin
                    if (t_q == '0) begin
                        state_q <= STATE_FETCH_INST;
                        t_q     <= t_inc;
                    end else begin
                        if (state_q == STATE_FETCH_INST) op_q <= opcode;
                        t_q <= t_inc;
                        if (!rom_valid || overrun) begin
                            state_q   <= STATE_TRAP;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q  <= rom_entry.state;
                            halted_q <= (rom_entry.state == STATE_HALT);
                        end
                    end
                end
            endcase
        end
    end

    assign state   = STATE_W'(state_q);
    assign t_cycle = t_q;
    assign irq_ack = irq_ack_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

endmodule
